// File: rtl/dec_pipe_stage.sv
// RV32I instruction-decode stage: combinational field/immediate extraction
// registered through a one-entry skid buffer with flush and valid/ready handshakes.
module dec_pipe_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [6:0]        opcode,
    output logic [2:0]        func3,
    output logic [6:0]        func7,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd,
    output logic              rs1_en,
    output logic              rs2_en,
    output logic              rd_en,
    output logic [XLEN-1:0]   imm,
    output logic              illegal
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              rs1_en;
        logic              rs2_en;
        logic              rd_en;
        logic [XLEN-1:0]   imm;
        logic              illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t  state_q, state_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    bundle_t dec;

    logic is_r, is_i, is_ld, is_s, is_lui, is_aui, is_b, is_jal, is_jalr, is_csr;
    logic is_shift;
    logic use_rs1, use_rs2, use_rd;
    logic in_fire, out_fire;

    // Format classification
    always_comb begin
        is_r    = 1'b0;
        is_i    = 1'b0;
        is_ld   = 1'b0;
        is_s    = 1'b0;
        is_lui  = 1'b0;
        is_aui  = 1'b0;
        is_b    = 1'b0;
        is_jal  = 1'b0;
        is_jalr = 1'b0;
        is_csr  = 1'b0;
        case (in_inst[6:0])
            7'b0110011: is_r    = 1'b1;
            7'b0010011: is_i    = 1'b1;
            7'b0000011: is_ld   = 1'b1;
            7'b0100011: is_s    = 1'b1;
            7'b0110111: is_lui  = 1'b1;
            7'b0010111: is_aui  = 1'b1;
            7'b1100011: is_b    = 1'b1;
            7'b1101111: is_jal  = 1'b1;
            7'b1100111: is_jalr = 1'b1;
            7'b1110011: is_csr  = 1'b1;
            default: ;
        endcase
    end

    assign is_shift = is_i && (in_inst[13:12] == 2'b01);
    assign use_rs1  = is_r | is_i | is_ld | is_s | is_b | is_jalr | is_csr;
    assign use_rs2  = is_r | is_s | is_b;
    assign use_rd   = is_r | is_i | is_ld | is_lui | is_aui | is_jal | is_jalr | is_csr;

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = in_inst[6:0];
        dec.illegal = ~(is_r | is_i | is_ld | is_s | is_lui | is_aui |
                        is_b | is_jal | is_jalr | is_csr) | (in_inst[1:0] != 2'b11);
        if (use_rs1) begin
            dec.func3  = in_inst[14:12];
            dec.rs1    = REG_AW'(in_inst[19:15]);
            dec.rs1_en = 1'b1;
        end
        if (use_rs2) begin
            dec.rs2    = REG_AW'(in_inst[24:20]);
            dec.rs2_en = 1'b1;
        end
        if (use_rd) begin
            dec.rd    = REG_AW'(in_inst[11:7]);
            dec.rd_en = (in_inst[11:7] != 5'd0);
        end
        if (is_r || is_shift) begin
            dec.func7 = in_inst[31:25];
        end
        if (is_shift) begin
            dec.imm = XLEN'(in_inst[24:20]);
        end else if (is_i || is_ld || is_jalr || is_csr) begin
            dec.imm = XLEN'($signed(in_inst[31:20]));
        end else if (is_s) begin
            dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
        end else if (is_b) begin
            dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                     in_inst[11:8], 1'b0}));
        end else if (is_lui || is_aui) begin
            dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
        end else if (is_jal) begin
            dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                     in_inst[30:21], 1'b0}));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Flush drops in-flight entries; data registers keep stale contents behind out_valid=0.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        out_d   = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        out_d = dec;
                    end else if (in_fire) begin
                        skid_d  = dec;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != ST_FULL) && !rst;
        out_valid = (state_q != ST_EMPTY);
        out_pc    = out_q.pc;
        opcode    = out_q.opcode;
        func3     = out_q.func3;
        func7     = out_q.func7;
        rs1       = out_q.rs1;
        rs2       = out_q.rs2;
        rd        = out_q.rd;
        rs1_en    = out_q.rs1_en;
        rs2_en    = out_q.rs2_en;
        rd_en     = out_q.rd_en;
        imm       = out_q.imm;
        illegal   = out_q.illegal;
    end

endmodule

// File: tb/tb_dec_pipe_stage.sv
// Directed self-checking bench for dec_pipe_stage with hand-computed expectations.
module tb_dec_pipe_stage;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              rs1_en, rs2_en, rd_en;
    logic [XLEN-1:0]   imm;
    logic              illegal;

    int unsigned n_checks;
    int unsigned n_fail;

    dec_pipe_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_en(rd_en),
        .imm(imm), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_illegal",   64'(illegal),   64'd0);
        check("rst_imm",       64'(imm),       64'd0);
        check("rst_opcode",    64'(opcode),    64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // add x10, x10, x11
        out_ready = 1'b1;
        drive(1'b1, 32'h00B50533, 32'h100);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("add_valid",   64'(out_valid), 64'd1);
        check("add_rs1",     64'(rs1),       64'd10);
        check("add_rs2",     64'(rs2),       64'd11);
        check("add_rd",      64'(rd),        64'd10);
        check("add_func7",   64'(func7),     64'd0);
        check("add_imm",     64'(imm),       64'd0);
        check("add_illegal", 64'(illegal),   64'd0);
        check("add_pc",      64'(out_pc),    64'h100);
        check("add_en",      64'({rs1_en, rs2_en, rd_en}), 64'b111);
        step();
        check("drain_valid", 64'(out_valid), 64'd0);

        // srai x1, x1, 3
        drive(1'b1, 32'h4030D093, 32'h104);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("srai_func3",  64'(func3),  64'd5);
        check("srai_func7",  64'(func7),  64'h20);
        check("srai_imm",    64'(imm),    64'd3);
        check("srai_rs2_en", 64'(rs2_en), 64'd0);
        check("srai_rs1_rd", 64'({rs1, rd}), 64'({5'd1, 5'd1}));
        step();

        // beq x2, x0, -4
        drive(1'b1, 32'hFE010EE3, 32'h108);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("beq_imm",   64'(imm),   64'hFFFFFFFC);
        check("beq_rd_en", 64'(rd_en), 64'd0);
        check("beq_rs1",   64'(rs1),   64'd2);
        step();

        // jal x1, -4
        drive(1'b1, 32'hFFDFF0EF, 32'h10C);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("jal_imm",    64'(imm),    64'hFFFFFFFC);
        check("jal_rs1_en", 64'(rs1_en), 64'd0);
        check("jal_rd",     64'({rd_en, rd}), 64'({1'b1, 5'd1}));
        check("jal_func3",  64'(func3),  64'd0);
        step();

        // sw x1, 12(x2)
        drive(1'b1, 32'h00112623, 32'h110);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("sw_imm",   64'(imm),   64'd12);
        check("sw_regs",  64'({rs1, rs2}), 64'({5'd2, 5'd1}));
        check("sw_rd_en", 64'({rd_en, rd}), 64'd0);
        check("sw_func3", 64'(func3), 64'd2);
        step();

        // lui x1, 0x12345
        drive(1'b1, 32'h123450B7, 32'h114);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("lui_imm",    64'(imm),    64'h12345000);
        check("lui_rs1_en", 64'(rs1_en), 64'd0);
        step();

        // Back-pressure: four instructions, out_ready low for three cycles
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h200);
        step();
        check("bp_rdy_after_1", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h00200113, 32'h204);
        step();
        check("bp_rdy_after_2", 64'(in_ready), 64'd0);
        check("bp_pc_hold_a",   64'(out_pc),   64'h200);
        drive(1'b1, 32'h00300193, 32'h208);
        step();
        check("bp_pc_hold_b",   64'(out_pc),   64'h200);
        check("bp_imm_hold",    64'(imm),      64'd1);
        check("bp_valid_hold",  64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_out_1", 64'(out_pc), 64'h204);
        check("bp_imm_1", 64'(imm),    64'd2);
        step();
        check("bp_out_2", 64'(out_pc), 64'h208);
        drive(1'b1, 32'h00400213, 32'h20C);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("bp_out_3", 64'(out_pc), 64'h20C);
        check("bp_rd_3",  64'(rd),     64'd4);
        step();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush in FULL with a third instruction offered
        out_ready = 1'b0;
        drive(1'b1, 32'h00500293, 32'h300);
        step();
        drive(1'b1, 32'h00600313, 32'h304);
        step();
        check("fl_full", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h00700393, 32'h308);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_no_emit", 64'(out_valid), 64'd0);
        end

        // Illegal opcodes still pass through
        drive(1'b1, 32'h0000007F, 32'h400);
        #1;
        check("ill1_ready", 64'(in_ready), 64'd1);
        step();
        drive(1'b1, 32'h00000000, 32'h404);
        check("ill1_flag",  64'(illegal),   64'd1);
        check("ill1_valid", 64'(out_valid), 64'd1);
        check("ill1_pc",    64'(out_pc),    64'h400);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("ill0_flag", 64'(illegal), 64'd1);
        check("ill0_pc",   64'(out_pc),  64'h404);
        step();

        // Reset while FULL discards both entries
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h500);
        step();
        drive(1'b1, 32'h00200113, 32'h504);
        step();
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_ready", 64'(in_ready),  64'd0);
        check("mrst_pc",    64'(out_pc),    64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("mrst_no_emit", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
